lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store initiator for the RV32I core: accepts one load or store request from the execute stage and computes the effective address. It checks alignment, then drives the byte-addressed data memory port (address, enables, write data, transfer size) until the memory signals MemRdy. Load data is sign- or zero-extended per funct3 before being returned to writeback. The block sits between the execute stage and the data memory, and stalls the pipeline while an access is in flight.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- base  in  32  rs1 value.
- offset  in  32  sign-extended immediate.
- store_data  in  32  rs2 value.
- mem_read_data  in  32  memory read data; low bytes valid, upper bytes zero for sub-word reads.
- MemRdy  in  1  memory ready/complete.
- mem_address  out  32  effective address to memory.
- mem_write_enable  out  1  store strobe.
- mem_read_enable  out  1  load strobe.
- mem_write_data  out  32  registered store_data, unmodified.
- mem_xfer_size  out  3  3'd1 byte, 3'd2 half, 3'd4 word.
- busy  out  1  high whenever state != IDLE; used as pipeline stall.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; misaligned address or illegal funct3.
- load_data  out  32  extended load result; valid when resp_valid=1 and resp_err=0.
- fault_addr  out  32  effective address of the failing request; valid when resp_err=1.

## Operation
- States: IDLE, ACCESS, RESP.
- Effective address: ea = base + offset, 32-bit, carry discarded (wraps modulo 2^32).
- Size from funct3[1:0]:
  - 0 → 1 byte
  - 1 → 2 bytes
  - 2 → 4 bytes
- Illegal funct3:
  - load with funct3 ∈ {3, 6, 7}
  - store with funct3 ≥ 3
- Misaligned:
  - half with ea[0]=1
  - word with ea[1:0]≠0
- IDLE: on req_valid=1:
  - Error case (illegal or misaligned): latch ea into fault_addr, set resp_err, go to RESP. No memory enable is ever asserted.
  - Otherwise: latch ea, size, store_data, req_store and funct3, then go to ACCESS.
- ACCESS:
  - mem_address, mem_xfer_size and mem_write_data come from the latched values.
  - mem_write_enable = latched store; mem_read_enable = latched load.
  - All outputs are held stable while MemRdy=0; the block waits indefinitely.
  - On the edge where MemRdy=1: a load captures extended data into load_data; resp_err is cleared; go to RESP.
  - The store commits on that same edge.
- Load extension:
  - LB: sign-extend [7:0]
  - LH: sign-extend [15:0]
  - LW: pass through
  - LBU: zero-extend [7:0]
  - LHU: zero-extend [15:0]
- RESP:
  - resp_valid=1 for exactly one cycle; then unconditionally go to IDLE.
  - req_valid is ignored in RESP and ACCESS.
- Stores: load_data is unchanged.
- load_data, resp_err and fault_addr hold their values until the next response.
- mem_read_enable and mem_write_enable are never both 1.

## Timing
- Reset (async, immediate) values:
  - state=IDLE
  - mem_address=0, mem_write_enable=0, mem_read_enable=0, mem_write_data=0
  - mem_xfer_size=3'd4
  - busy=0, resp_valid=0, resp_err=0
  - load_data=0, fault_addr=0
- Request sampled at edge N (IDLE):
  - ACCESS during cycle N+1.
  - With MemRdy=1, RESP during N+2: resp_valid=1, busy=1.
  - IDLE during N+3.
- Throughput: one request per 3 cycles at zero wait states.
- Each MemRdy=0 cycle in ACCESS adds exactly one cycle of latency.
- Error path: request at edge N gives RESP during N+1 and IDLE during N+2.
- Outside ACCESS, both enables are 0. mem_address and mem_xfer_size retain their last values.
- Reset asserted in ACCESS: enables drop immediately (asynchronously). No resp_valid is produced for the aborted request.
- MemRdy is ignored outside ACCESS.

## Test plan
- SW then LW, MemRdy=1:
  - Stimulus: base=0x10, offset=0x4, store_data=0xDEADBEEF, then the same address as a load.
  - Response: write strobe for 1 cycle at address 0x14, size 4; then resp_valid at N+2 with load_data=0xDEADBEEF.
- Load extension at address 0x14 holding 0xDEADBEEF (mem_read_data supplied zero-extended):
  - LB → 0xFFFFFFEF
  - LBU → 0x000000EF
  - LH → 0xFFFFBEEF
  - LHU → 0x0000BEEF
- Misaligned and illegal requests:
  - LW at ea=0x22 → resp_valid with resp_err=1 and fault_addr=0x22 at N+1; no enable ever asserted.
  - SH at ea=0x21 → same behaviour.
  - Load with funct3=3 → same behaviour.
- Wait states:
  - Stimulus: hold MemRdy=0 for 3 cycles during an SB to 0x7 with store_data 0x12345678.
  - Response: address 0x7, size 1 and write_data stable for 4 cycles; resp_valid 3 cycles later than baseline; busy high throughout.
- Address wrap: base=0xFFFFFFFC, offset=0x8 → mem_address=0x00000004.
- Reset mid-ACCESS (MemRdy=0):
  - Enables go to 0 before the next edge; no resp_valid.
  - A fresh request after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : RV32I load/store initiator. Takes one request from execute,
//                forms the effective address, screens it for illegal funct3
//                and misalignment, drives the byte-addressed data memory port
//                until MemRdy, and returns extended load data to writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_read_data,
    input  logic        MemRdy,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_xfer_size,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] load_data,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] c_SIZE_BYTE = 3'd1;
    localparam logic [2:0] c_SIZE_HALF = 3'd2;
    localparam logic [2:0] c_SIZE_WORD = 3'd4;

    state_t      state_q,      state_d;
    logic [31:0] addr_q,       addr_d;
    logic [2:0]  size_q,       size_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        store_q,      store_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic [31:0] load_data_q,  load_data_d;
    logic        resp_err_q,   resp_err_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [31:0] w_ea;
    logic [2:0]  w_size;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_err;
    logic [31:0] w_ext;

    // Request screening: effective address (wraps mod 2^32), size and error flags
    always_comb begin
        w_ea = base + offset;
        case (funct3[1:0])
            2'd0:    w_size = c_SIZE_BYTE;
            2'd1:    w_size = c_SIZE_HALF;
            default: w_size = c_SIZE_WORD;
        endcase
        if (req_store) begin
            w_illegal = (funct3 >= 3'd3);
        end else begin
            w_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        w_misaligned = ((funct3[1:0] == 2'd1) && w_ea[0]) ||
                       ((funct3[1:0] == 2'd2) && (w_ea[1:0] != 2'b00));
        w_err = w_illegal || w_misaligned;
    end

    // Load data extension selected by the latched funct3
    always_comb begin
        case (funct3_q)
            3'd0:    w_ext = {{24{mem_read_data[7]}},  mem_read_data[7:0]};
            3'd1:    w_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'd4:    w_ext = {24'd0, mem_read_data[7:0]};
            3'd5:    w_ext = {16'd0, mem_read_data[15:0]};
            default: w_ext = mem_read_data;
        endcase
    end

    // Next-state and datapath update logic; every register holds by default
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        load_data_d  = load_data_q;
        resp_err_d   = resp_err_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        // Faulting requests never reach memory; the port keeps its old values
                        fault_addr_d = w_ea;
                        resp_err_d   = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        addr_d   = w_ea;
                        size_d   = w_size;
                        wdata_d  = store_data;
                        store_d  = req_store;
                        funct3_d = funct3;
                        state_d  = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (MemRdy) begin
                    if (!store_q) begin
                        load_data_d = w_ext;
                    end
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            size_q       <= c_SIZE_WORD;
            wdata_q      <= 32'd0;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            load_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            load_data_q  <= load_data_d;
            resp_err_q   <= resp_err_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Strobes decode from state so an asynchronous reset drops them at once
    always_comb begin
        mem_address      = addr_q;
        mem_xfer_size    = size_q;
        mem_write_data   = wdata_q;
        mem_write_enable = (state_q == S_ACCESS) && store_q;
        mem_read_enable  = (state_q == S_ACCESS) && !store_q;
        busy             = (state_q != S_IDLE);
        resp_valid       = (state_q == S_RESP);
        resp_err         = resp_err_q;
        load_data        = load_data_q;
        fault_addr       = fault_addr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Self-checking bench for lsu_mem_ctrl. Acts as the data
//                memory and compares the block against a transaction-level
//                reference model of the load/store rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] mem_read_data;
    logic        MemRdy;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_xfer_size;
    logic        busy;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic [31:0] fault_addr;

    lsu_mem_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_store        (req_store),
        .funct3           (funct3),
        .base             (base),
        .offset           (offset),
        .store_data       (store_data),
        .mem_read_data    (mem_read_data),
        .MemRdy           (MemRdy),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .busy             (busy),
        .resp_valid       (resp_valid),
        .resp_err         (resp_err),
        .load_data        (load_data),
        .fault_addr       (fault_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // phys: the memory the DUT actually drives; refm: the model's view
    logic [7:0]  phys [256];
    logic [7:0]  refm [256];
    logic [31:0] exp_load;
    logic [31:0] exp_fault;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Reference load result: gather bytes, then extend arithmetically
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea);
        logic [31:0] v;
        int n;
        n = nbytes_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(refm[8'(ea + 32'(i))]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < 4; i++)
            if (i < int'(sz)) v = v | (32'(phys[8'(a + 32'(i))]) << (8 * i));
        return v;
    endfunction

    // One request, starting and ending at a negedge with the DUT idle
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] sd, input int waits);
        logic [31:0] ea;
        logic        illegal, mis, err;
        int          n;
        ea      = b + o;
        n       = nbytes_of(f3);
        illegal = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
        mis     = (n == 2 && ea[0]) || (n == 4 && ea[1:0] != 2'b00);
        err     = illegal || mis;
        req_valid = 1'b1; req_store = st; funct3 = f3;
        base = b; offset = o; store_data = sd;
        MemRdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        req_valid = 1'b0; base = $urandom; offset = $urandom; store_data = $urandom;
        funct3 = 3'($urandom); req_store = 1'($urandom);
        if (err) begin
            exp_err   = 1'b1;
            exp_fault = ea;
            chk("err_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("err_resp_err",   {31'd0, resp_err},   32'd1);
            chk("err_fault_addr", fault_addr, ea);
            chk("err_busy",       {31'd0, busy},       32'd1);
            chk("err_enables",    {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        end else begin
            for (int k = 0; k <= waits; k++) begin
                chk("acc_busy",    {31'd0, busy},       32'd1);
                chk("acc_resp",    {31'd0, resp_valid}, 32'd0);
                chk("acc_addr",    mem_address, ea);
                chk("acc_size",    {29'd0, mem_xfer_size}, 32'(n));
                chk("acc_enables", {30'd0, mem_write_enable, mem_read_enable}, {30'd0, st, ~st});
                if (st) chk("acc_wdata", mem_write_data, sd);
                MemRdy = (k == waits);
                mem_read_data = mem_read_enable ? phys_read(mem_address, mem_xfer_size) : $urandom;
                if (mem_write_enable && MemRdy)
                    for (int i = 0; i < 4; i++)
                        if (i < int'(mem_xfer_size))
                            phys[8'(mem_address + 32'(i))] = mem_write_data[8*i +: 8];
                @(negedge clk);
            end
            MemRdy = 1'($urandom_range(0, 1));
            if (st) begin
                for (int i = 0; i < n; i++) refm[8'(ea + 32'(i))] = sd[8*i +: 8];
            end else begin
                exp_load = model_load(f3, ea);
            end
            exp_err = 1'b0;
            chk("ok_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("ok_resp_err",   {31'd0, resp_err},   32'd0);
            chk("ok_load_data",  load_data, exp_load);
            chk("ok_busy",       {31'd0, busy},       32'd1);
            chk("ok_enables",    {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        end
        @(negedge clk);
        chk("idle_busy",       {31'd0, busy},       32'd0);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_resp_err",   {31'd0, resp_err},   {31'd0, exp_err});
        chk("idle_fault_addr", fault_addr, exp_fault);
        chk("idle_load_data",  load_data, exp_load);
        chk("idle_enables",    {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] b;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            phys[i] = r[7:0];
            refm[i] = r[7:0];
        end
        exp_load = 0; exp_fault = 0; exp_err = 0;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; funct3 = 3'd0;
        base = 0; offset = 0; store_data = 0; mem_read_data = 0; MemRdy = 1'b0;
        #1;
        chk("rst_addr",       mem_address, 32'd0);
        chk("rst_enables",    {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        chk("rst_wdata",      mem_write_data, 32'd0);
        chk("rst_size",       {29'd0, mem_xfer_size}, 32'd4);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        chk("rst_load_data",  load_data, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // SW then LW, followed by each sub-word load flavour at 0x14
        txn(1'b1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF, 0);
        txn(1'b0, 3'd2, 32'h10, 32'h4, 32'h0, 0);
        chk("lw_deadbeef", load_data, 32'hDEADBEEF);
        txn(1'b0, 3'd0, 32'h14, 32'h0, 32'h0, 0);
        chk("lb",  load_data, 32'hFFFFFFEF);
        txn(1'b0, 3'd4, 32'h14, 32'h0, 32'h0, 0);
        chk("lbu", load_data, 32'h000000EF);
        txn(1'b0, 3'd1, 32'h14, 32'h0, 32'h0, 0);
        chk("lh",  load_data, 32'hFFFFBEEF);
        txn(1'b0, 3'd5, 32'h14, 32'h0, 32'h0, 0);
        chk("lhu", load_data, 32'h0000BEEF);

        // Misaligned and illegal requests
        txn(1'b0, 3'd2, 32'h20, 32'h2, 32'h0, 0);
        chk("lw_mis_fault", fault_addr, 32'h22);
        txn(1'b1, 3'd1, 32'h20, 32'h1, 32'h55AA55AA, 0);
        chk("sh_mis_fault", fault_addr, 32'h21);
        txn(1'b0, 3'd3, 32'h30, 32'h0, 32'h0, 0);
        txn(1'b1, 3'd4, 32'h30, 32'h0, 32'h0, 0);

        // Wait states, address wrap
        txn(1'b1, 3'd0, 32'h0, 32'h7, 32'h12345678, 3);
        txn(1'b0, 3'd4, 32'h7, 32'h0, 32'h0, 1);
        chk("sb_readback", load_data, 32'h00000078);
        txn(1'b1, 3'd2, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 0);
        chk("wrap_addr", mem_address, 32'h00000004);

        // Reset while a load waits in ACCESS
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'd2;
        base = 32'h40; offset = 32'h0; MemRdy = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_read_en", {31'd0, mem_read_enable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_enables", {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        chk("abort_busy",    {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        MemRdy = 1'b1;
        exp_load = 0; exp_fault = 0; exp_err = 0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 3'd2, 32'h10, 32'h4, 32'h0, 0);
        chk("after_abort_lw", load_data, 32'hDEADBEEF);

        // Randomized mix against the reference model
        for (int t = 0; t < 200; t++) begin
            r = $urandom;
            b = $urandom;
            if (r[0]) b[1:0] = 2'b00;
            txn(r[1], 3'(r[4:2]), b, {{20{r[16]}}, r[16:5]}, $urandom, int'(r[18:17]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
